// File: rtl/csr_pins_pwm.sv
// CSR-mapped output pins: each pin is a static level or a PWM waveform driven by
// a shared prescaler/phase counter, with duty values shadowed at period boundaries.
module csr_pins_pwm #(
  parameter logic [11:0] BASE_ADDR = 12'hbc1,
  parameter int          COUNT     = 8,
  parameter int          RES       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             read,
  input  logic [2:0]       modify,
  input  logic [31:0]      wdata,
  input  logic [11:0]      addr,
  output logic [31:0]      rdata,
  output logic             valid,
  output logic [COUNT-1:0] pins
);

  localparam logic [11:0] NREG = 12'(COUNT + 3);

  logic [COUNT-1:0] level_q;
  logic [COUNT-1:0] mode_q;
  logic [15:0]      prescale_q;
  logic [15:0]      pre_cnt_q;
  logic [RES-1:0]   phase_q;
  logic [RES-1:0]   duty_q     [COUNT];
  logic [RES-1:0]   duty_act_q [COUNT];
  logic [COUNT-1:0] pins_q;

  logic [11:0] offset;
  logic        hit;
  logic        wr_en;
  logic [31:0] cur;
  logic [31:0] nxt;
  logic        tick;
  logic        wrap;

  // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both sides.
  assign offset = addr - BASE_ADDR;
  assign hit    = (offset < NREG);
  assign valid  = hit & (read | (modify != 3'b000));
  assign wr_en  = hit & (modify != 3'b000);
  assign rdata  = valid ? cur : 32'd0;

  // NOTE: every output of this block gets a default first, so no path leaves cur unassigned (no latch).
  always_comb begin
    cur = '0;
    if (offset == 12'd0) cur[COUNT-1:0] = level_q;
    if (offset == 12'd1) cur[COUNT-1:0] = mode_q;
    if (offset == 12'd2) cur[15:0]      = prescale_q;
    for (int i = 0; i < COUNT; i++) begin
      if (offset == 12'(i + 3)) cur[RES-1:0] = duty_q[i];
    end
  end

  // Illegal multi-hot modify resolves as write > set > clear.
  always_comb begin
    if (modify[0])      nxt = wdata;
    else if (modify[1]) nxt = cur | wdata;
    else                nxt = cur & ~wdata;
  end

  // ">=" so a PRESCALE written below pre_cnt ends the interval on the next cycle.
  assign tick = (pre_cnt_q >= prescale_q);
  assign wrap = tick & (&phase_q);

  // NOTE: sequential state uses non-blocking assignments, so duty_act loads the
  // pre-edge DUTY value even when a DUTY write lands on the wrap edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q    <= '0;
      mode_q     <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      phase_q    <= '0;
      pins_q     <= '0;
      // NOTE: the duty arrays are small registers, not RAM, so they are reset explicitly.
      for (int i = 0; i < COUNT; i++) begin
        duty_q[i]     <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      if (wr_en && offset == 12'd0) level_q    <= nxt[COUNT-1:0];
      if (wr_en && offset == 12'd1) mode_q     <= nxt[COUNT-1:0];
      if (wr_en && offset == 12'd2) prescale_q <= nxt[15:0];

      pre_cnt_q <= tick ? 16'd0 : pre_cnt_q + 16'd1;
      if (tick) phase_q <= phase_q + RES'(1);

      for (int i = 0; i < COUNT; i++) begin
        if (wr_en && offset == 12'(i + 3)) duty_q[i] <= nxt[RES-1:0];
        if (wrap) duty_act_q[i] <= duty_q[i];
        pins_q[i] <= mode_q[i] ? (phase_q < duty_act_q[i]) : level_q[i];
      end
    end
  end

  assign pins = pins_q;

endmodule

// File: tb/tb_csr_pins_pwm.sv
// Directed bench for csr_pins_pwm: CSR responses go through a scoreboard queue,
// pin waveforms are checked by counting high/low cycles.
module tb_csr_pins_pwm;

  localparam logic [11:0] BASE = 12'hbc1;
  localparam int COUNT = 8;
  localparam int RES   = 8;

  localparam logic [2:0] M_NONE = 3'b000;
  localparam logic [2:0] M_WR   = 3'b001;
  localparam logic [2:0] M_SET  = 3'b010;
  localparam logic [2:0] M_CLR  = 3'b100;

  localparam logic [11:0] A_LEVEL = BASE;
  localparam logic [11:0] A_MODE  = BASE + 12'd1;
  localparam logic [11:0] A_PRE   = BASE + 12'd2;
  localparam logic [11:0] A_DUTY0 = BASE + 12'd3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             read;
  logic [2:0]       modify;
  logic [31:0]      wdata;
  logic [11:0]      addr;
  logic [31:0]      rdata;
  logic             valid;
  logic [COUNT-1:0] pins;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  csr_pins_pwm #(.BASE_ADDR(BASE), .COUNT(COUNT), .RES(RES)) dut (
    .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata),
    .addr(addr), .rdata(rdata), .valid(valid), .pins(pins)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented response is matched against the oldest expectation.
  always begin
    @(negedge clk);
    #2;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("csr_rdata", rdata, sb.pop_front());
      end
    end
  end

  // One CSR access, driven at a falling edge and held over the next rising edge.
  task automatic csr_op(input logic [2:0] mod, input logic [11:0] a, input logic [31:0] d,
                        input logic rd, input logic exp_hit, input logic [31:0] exp_rdata);
    read = rd; modify = mod; wdata = d; addr = a;
    if (exp_hit) sb.push_back(exp_rdata);
    #2;
    if (!exp_hit) begin
      check("miss_valid", {31'd0, valid}, 32'd0);
      check("miss_rdata", rdata, 32'd0);
    end
    @(negedge clk);
    read = 1'b0; modify = M_NONE;
  endtask

  task automatic wait_rise();
    int n = 0;
    while (pins[0] && n < 3000) begin @(negedge clk); n++; end
    while (!pins[0] && n < 3000) begin @(negedge clk); n++; end
    if (!pins[0]) check("wait_rise_timeout", 32'd0, 32'd1);
  endtask

  // Called at the first sample after a rising edge; returns at the next rise.
  task automatic measure(input int write_at, input logic [31:0] wd, input logic [31:0] wold,
                         output int hi, output int lo);
    int cyc = 0;
    hi = 0; lo = 0;
    while (pins[0] && hi < 2000) begin
      hi++;
      if (cyc == write_at) csr_op(M_WR, A_DUTY0, wd, 1'b0, 1'b1, wold);
      else @(negedge clk);
      cyc++;
    end
    while (!pins[0] && lo < 2000) begin
      lo++;
      if (cyc == write_at) csr_op(M_WR, A_DUTY0, wd, 1'b0, 1'b1, wold);
      else @(negedge clk);
      cyc++;
    end
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      if (pins[0]) hi++;
      @(negedge clk);
    end
  endtask

  int hi, lo;

  initial begin
    rstn = 1'b0; read = 1'b0; modify = M_NONE; wdata = '0; addr = '0;
    repeat (3) @(negedge clk);
    check("reset_pins", {24'd0, pins}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Reset values and address decode boundaries.
    csr_op(M_NONE, A_LEVEL, 0, 1'b1, 1'b1, 32'd0);
    csr_op(M_NONE, A_MODE,  0, 1'b1, 1'b1, 32'd0);
    csr_op(M_NONE, A_PRE,   0, 1'b1, 1'b1, 32'd0);
    csr_op(M_NONE, A_DUTY0, 0, 1'b1, 1'b1, 32'd0);
    csr_op(M_NONE, BASE + 12'd10, 0, 1'b1, 1'b1, 32'd0);
    csr_op(M_NONE, BASE + 12'd11, 0, 1'b1, 1'b0, 32'd0);
    csr_op(M_WR,   BASE - 12'd1, 32'hff, 1'b0, 1'b0, 32'd0);
    check("pins_after_reset", {24'd0, pins}, 32'd0);

    // Write / set / clear on LEVEL; each modify returns the prior value.
    csr_op(M_WR,  A_LEVEL, 32'hA5, 1'b0, 1'b1, 32'h00);
    csr_op(M_SET, A_LEVEL, 32'h02, 1'b0, 1'b1, 32'hA5);
    csr_op(M_CLR, A_LEVEL, 32'h80, 1'b0, 1'b1, 32'hA7);
    check("level_latency", {24'd0, pins}, 32'hA7);
    csr_op(M_NONE, A_LEVEL, 0, 1'b1, 1'b1, 32'h27);
    check("level_pins", {24'd0, pins}, 32'h27);

    // Upper bits ignored; multi-hot modify resolves with set above clear.
    csr_op(M_WR, A_LEVEL, 32'hFFFF_FF27, 1'b0, 1'b1, 32'h27);
    csr_op(M_SET | M_CLR, A_LEVEL, 32'h10, 1'b0, 1'b1, 32'h27);
    csr_op(M_CLR, A_LEVEL, 32'h10, 1'b1, 1'b1, 32'h37);
    csr_op(M_WR, A_PRE, 32'h0001_0000, 1'b0, 1'b1, 32'h0);
    csr_op(M_NONE, A_PRE, 0, 1'b1, 1'b1, 32'h0);

    // PWM on pin 0, PRESCALE=0.
    csr_op(M_WR, A_DUTY0, 32'd64, 1'b0, 1'b1, 32'd0);
    csr_op(M_WR, A_MODE,  32'h01, 1'b0, 1'b1, 32'd0);
    repeat (520) @(negedge clk);
    count_high(256, hi);
    check("duty64_high", hi, 32'd64);
    check("static_pins_in_pwm", {25'd0, pins[7:1]}, 32'h13);
    csr_op(M_WR, A_DUTY0, 32'd0, 1'b0, 1'b1, 32'd64);
    repeat (520) @(negedge clk);
    count_high(256, hi);
    check("duty0_high", hi, 32'd0);

    // PRESCALE=3, duty 128: period 1024, high 512.
    csr_op(M_WR, A_PRE,   32'h0001_0003, 1'b0, 1'b1, 32'd0);
    csr_op(M_WR, A_DUTY0, 32'd128, 1'b0, 1'b1, 32'd0);
    csr_op(M_NONE, A_PRE, 0, 1'b1, 1'b1, 32'd3);
    repeat (2100) @(negedge clk);
    count_high(1024, hi);
    check("pre3_window_high", hi, 32'd512);
    wait_rise();
    measure(-1, 0, 0, hi, lo);
    check("pre3_pulse_high", hi, 32'd512);
    check("pre3_pulse_low",  lo, 32'd512);

    // Mid-period duty change 64 -> 192: current period unchanged, no runt.
    csr_op(M_WR, A_PRE,   32'd0,  1'b0, 1'b1, 32'd3);
    csr_op(M_WR, A_DUTY0, 32'd64, 1'b0, 1'b1, 32'd128);
    repeat (1100) @(negedge clk);
    wait_rise();
    measure(10, 32'd192, 32'd64, hi, lo);
    check("midchg_cur_high", hi, 32'd64);
    check("midchg_cur_low",  lo, 32'd192);
    measure(-1, 0, 0, hi, lo);
    check("midchg_next_high", hi, 32'd192);
    check("midchg_next_low",  lo, 32'd64);

    // Rise seen after edge R means wrap was at R-1; next wrap at R+255.
    repeat (254) @(negedge clk);
    csr_op(M_WR, A_DUTY0, 32'd64, 1'b0, 1'b1, 32'd192);
    wait_rise();
    measure(-1, 0, 0, hi, lo);
    check("wrapwr_old_high", hi, 32'd192);
    check("wrapwr_old_low",  lo, 32'd64);
    measure(-1, 0, 0, hi, lo);
    check("wrapwr_new_high", hi, 32'd64);
    check("wrapwr_new_low",  lo, 32'd192);

    // Asynchronous reset in the middle of a high pulse.
    repeat (5) @(negedge clk);
    check("pin_high_before_rst", {31'd0, pins[0]}, 32'd1);
    #3 rstn = 1'b0;
    #1 check("async_rst_pins", {24'd0, pins}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    csr_op(M_NONE, A_DUTY0, 0, 1'b1, 1'b1, 32'd0);
    csr_op(M_NONE, A_MODE,  0, 1'b1, 1'b1, 32'd0);
    repeat (3) @(negedge clk);
    check("pins_after_rerst", {24'd0, pins}, 32'd0);

    @(negedge clk);
    #3 check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csr_pins_pwm.md
# csr_pins_pwm

CSR-mapped output-pin block with per-channel PWM, the parametrised successor to the plain CSR LED/pin register. It sits on the core's CSR bus next to the counter and UART CSR units. Its `rdata`/`valid` are OR-combined with the other CSR units. Each of `COUNT` pins is either a static level or a PWM waveform. The waveform comes from a shared prescaler and phase counter, with glitch-free duty updates at period boundaries.

## Interface
Parameters:
- `BASE_ADDR`, 12'hbc1, CSR address of the first register.
- `COUNT`, 8, number of pins/channels, 1..32.
- `RES`, 8, PWM resolution in bits, 1..16; the period is 2^RES phase steps.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `read`  in  1  CSR read request this cycle.
- `modify`  in  3  one-hot: [0] write, [1] set bits, [2] clear bits; 0 = no modification.
- `wdata`  in  32  CSR write operand.
- `addr`  in  12  CSR address.
- `rdata`  out  32  current (pre-modify) register value when hit, else 0.
- `valid`  out  1  address hit with `read` or nonzero `modify`.
- `pins`  out  COUNT  registered pin outputs.

## Operation
- Register map, offset from `BASE_ADDR`:
  - +0 LEVEL[COUNT-1:0]: static level per pin.
  - +1 MODE[COUNT-1:0]: 0 = static, 1 = PWM.
  - +2 PRESCALE[15:0].
  - +3+i DUTY_i[RES-1:0], for i = 0..COUNT-1.
- Unused high bits read 0 and ignore writes.
- Addresses outside BASE_ADDR..BASE_ADDR+2+COUNT produce `valid`=0 and `rdata`=0.
- `valid`/`rdata` are combinational from `addr`/`read`/`modify`.
- Modify semantics, applied at the clock edge when hit:
  - write: reg <= wdata.
  - set: reg <= reg | wdata.
  - clear: reg <= reg & ~wdata.
  - `modify` with more than one bit set is illegal; the block applies write > set > clear priority.
- Prescaler:
  - `pre_cnt` counts 0..PRESCALE.
  - `tick` = (pre_cnt == PRESCALE); pre_cnt returns to 0 on tick.
  - PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE below the current pre_cnt forces a tick on the next cycle. The compare is ">=" and the spec accepts that one shortened interval.
- Phase:
  - RES-bit `phase` increments on tick and wraps 2^RES-1 -> 0.
  - `wrap` = tick & (phase == 2^RES-1).
- Duty shadowing:
  - The PWM compare uses `duty_act_i`.
  - `duty_act_i` loads DUTY_i on `wrap`, so new duty applies from the next period start and never mid-period.
  - Reads return DUTY_i (the written value), not the active copy.
- Pin output:
  - `pins[i]` <= MODE[i] ? (phase < duty_act_i) : LEVEL[i].
  - duty 0 gives a constant 0; duty 2^RES-1 gives high for all but one step per period. A constant 1 is produced in static mode.
- Mode switch takes effect on the next edge; it does not wait for a wrap.

## Timing
- Reset (rstn=0, asynchronous) sets:
  - LEVEL, MODE, PRESCALE, DUTY_i, duty_act_i, pre_cnt, phase to 0.
  - `pins` to 0.
  - `rdata`/`valid` follow inputs combinationally (0 when no hit).
- Release of reset is clean on the next edge. Reset mid-period abandons the period, with no partial shadow load.
- CSR write at edge N: register holds the new value after N. A static pin reflects it after edge N+1 (one cycle of output latency).
- `rdata` during a modify cycle returns the old value, matching CSR read-modify-write semantics.
- Simultaneous DUTY_i write and `wrap` at the same edge: `duty_act_i` loads the OLD DUTY_i. The new value applies after the following wrap.
- PWM period = (PRESCALE+1)·2^RES cycles. High time = duty_act_i·(PRESCALE+1) cycles.
- No stalls or backpressure: every access completes in one cycle.

## Test plan
- Reset, then read +0/+1/+2/+3 -> `valid`=1, `rdata`=0. Read BASE_ADDR+3+COUNT -> `valid`=0, `rdata`=0. `pins`=0.
- Write LEVEL=8'hA5, set 8'h02, clear 8'h80 -> reads 8'h27. `pins`=8'h27 one cycle after the last edge. `rdata` in the modify cycle shows the prior value.
- RES=8, PRESCALE=0, MODE=8'h01, DUTY_0=64 -> after the first wrap, pin0 is high for 64 of every 256 cycles. DUTY_0=0 gives constant low.
- PRESCALE=3, DUTY_0=128 -> period 1024 cycles, high 512.
- Change DUTY_0 64->192 mid-period -> current period stays 64 high. The next period is 192 high, with no runt pulse.
- Write DUTY_0 on the exact wrap edge -> old duty is held for one more period.
- Assert rstn low asynchronously mid-period -> `pins` drop to 0 immediately.
